cga_line_capture: RTL and testbench

CGA_LINE_CAPTURE -- requirements
Module: cga_line_capture

---
 rtl/cga_line_capture_if.sv | 31 +++
 rtl/cga_line_capture.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_cga_line_capture.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cga_line_capture_if.sv
// cga_line_capture_if: bundles the sampler strobe stream, the CGA syncs and the
// line-buffer write port that leave the capture block.
interface cga_line_capture_if;
  logic        pix_valid;
  logic [3:0]  pix_data;
  logic        hs;
  logic        vs;
  logic        wr_en;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic [3:0]  wr_data;
  logic        line_done;
  logic        frame_done;
  logic        short_line_err;
  logic        frame_err;
  logic [10:0] meas_hcount;

  // Source side: sampler and sync front end, observes the write port and status
  modport master (
    output pix_valid, pix_data, hs, vs,
    input  wr_en, wr_x, wr_y, wr_data, line_done, frame_done,
           short_line_err, frame_err, meas_hcount
  );

  // Capture side: consumes samples and syncs, produces writes and status
  modport slave (
    input  pix_valid, pix_data, hs, vs,
    output wr_en, wr_x, wr_y, wr_data, line_done, frame_done,
           short_line_err, frame_err, meas_hcount
  );
endinterface

// File: rtl/cga_line_capture.sv
// cga_line_capture: windows the active area of a CGA raster out of the sampler's
// pix_valid strobe stream and turns each active pixel into a line-buffer write.
// Optional feature macro: CAPTURE_HMEAS_EN enables the per-line strobe count
// reported on meas_hcount; without it meas_hcount is tied to zero.

// Protocol checker for the capture block's output behaviour.
module cga_line_capture_chk #(
  parameter int unsigned H_ACTIVE = 640
) (
  input logic       clk,
  input logic       reset,
  input logic       wr_en,
  input logic [9:0] wr_x,
  input logic       line_done,
  input logic       frame_done,
  input logic       short_line_err,
  input logic       frame_err
);
  a_reset_quiet: assert property (@(posedge clk)
    $past(reset) |-> !(wr_en || line_done || frame_done || short_line_err || frame_err))
    else $error("capture outputs not cleared after reset");

  a_x_range: assert property (@(posedge clk) disable iff (reset)
    wr_en |-> (32'(wr_x) < H_ACTIVE))
    else $error("write column outside the active width");

  a_frame_no_write: assert property (@(posedge clk) disable iff (reset)
    frame_done |-> !wr_en)
    else $error("write coincides with frame_done");

  a_short_sticky: assert property (@(posedge clk) disable iff (reset)
    ($past(short_line_err) && !$past(reset)) |-> short_line_err)
    else $error("short_line_err dropped without reset");

  a_frame_sticky: assert property (@(posedge clk) disable iff (reset)
    ($past(frame_err) && !$past(reset)) |-> frame_err)
    else $error("frame_err dropped without reset");
endmodule

module cga_line_capture #(
  parameter int unsigned H_BACKPORCH = 48,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_BACKPORCH = 36,
  parameter int unsigned V_ACTIVE    = 200
) (
  input  logic              clk,
  input  logic              reset,
  cga_line_capture_if.slave cap
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VBP    = 3'd1,
    HBP    = 3'd2,
    ACTIVE = 3'd3,
    HWAIT  = 3'd4
  } state_t;

  localparam logic [10:0] HBP_CNT   = 11'(H_BACKPORCH);
  localparam logic [9:0]  HACT_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  VBP_CNT   = 10'(V_BACKPORCH);
  localparam logic [8:0]  VACT_LAST = 9'(V_ACTIVE - 1);
  // With no horizontal back porch the first strobe of a line is already pixel 0.
  localparam state_t      HBP_ENTRY = (H_BACKPORCH == 0) ? ACTIVE : HBP;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  state_t      state_r, state_s;
  logic        hs_d_r, vs_d_r;
  logic        hs_fall_s, vs_fall_s, vs_rise_s;
  logic [9:0]  line_cnt_r, line_cnt_s;
  logic [10:0] strobe_cnt_r, strobe_cnt_s;
  logic [9:0]  pix_x_r, pix_x_s;
  logic        wr_en_r, wr_en_s;
  logic [9:0]  wr_x_r, wr_x_s;
  logic [8:0]  wr_y_r, wr_y_s;
  logic [3:0]  wr_data_r, wr_data_s;
  logic        line_done_r, line_done_s;
  logic        frame_done_r, frame_done_s;
  logic        short_err_r, short_err_s;
  logic        frame_err_r, frame_err_s;
  logic        line_end_s;

  assign hs_fall_s = hs_d_r & ~cap.hs;
  assign vs_fall_s = vs_d_r & ~cap.vs;
  assign vs_rise_s = ~vs_d_r & cap.vs;

  // Sequencer next state plus next values of counters and registered outputs
  always_comb begin
    state_s      = state_r;
    line_cnt_s   = line_cnt_r;
    strobe_cnt_s = strobe_cnt_r;
    pix_x_s      = pix_x_r;
    wr_en_s      = 1'b0;
    wr_x_s       = wr_x_r;
    wr_y_s       = wr_y_r;
    wr_data_s    = wr_data_r;
    line_done_s  = 1'b0;
    frame_done_s = 1'b0;
    short_err_s  = short_err_r;
    frame_err_s  = frame_err_r;
    line_end_s   = 1'b0;

    if (vs_rise_s && (state_r != IDLE)) begin
      // vsync returning mid-frame: drop everything, no write this cycle
      frame_err_s = 1'b1;
      state_s     = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (vs_fall_s) begin
            state_s    = VBP;
            line_cnt_s = 10'd0;
          end else begin
            state_s = IDLE;
          end
        end
        VBP: begin
          if (hs_fall_s) begin
            line_cnt_s = sat_inc10(line_cnt_r);
            if (sat_inc10(line_cnt_r) >= VBP_CNT) begin
              state_s      = HBP_ENTRY;
              wr_y_s       = 9'd0;
              strobe_cnt_s = 11'd0;
              pix_x_s      = 10'd0;
            end else begin
              state_s = VBP;
            end
          end else begin
            state_s = VBP;
          end
        end
        HBP: begin
          if (hs_fall_s) begin
            short_err_s = 1'b1;
            line_done_s = 1'b1;
            line_end_s  = 1'b1;
          end else if (cap.pix_valid) begin
            strobe_cnt_s = sat_inc11(strobe_cnt_r);
            if (sat_inc11(strobe_cnt_r) >= HBP_CNT) begin
              state_s = ACTIVE;
              pix_x_s = 10'd0;
            end else begin
              state_s = HBP;
            end
          end else begin
            state_s = HBP;
          end
        end
        ACTIVE: begin
          if (hs_fall_s) begin
            short_err_s = 1'b1;
            line_done_s = 1'b1;
            line_end_s  = 1'b1;
          end else if (cap.pix_valid) begin
            wr_en_s   = 1'b1;
            wr_x_s    = pix_x_r;
            wr_data_s = cap.pix_data;
            if (pix_x_r == HACT_LAST) begin
              line_done_s = 1'b1;
              state_s     = HWAIT;
            end else begin
              pix_x_s = sat_inc10(pix_x_r);
            end
          end else begin
            state_s = ACTIVE;
          end
        end
        HWAIT: begin
          if (hs_fall_s) begin
            line_end_s = 1'b1;
          end else begin
            state_s = HWAIT;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end

    // End of a capture line: either the frame is complete or the next line starts
    if (line_end_s) begin
      if (wr_y_r == VACT_LAST) begin
        frame_done_s = 1'b1;
        state_s      = IDLE;
      end else begin
        wr_y_s       = wr_y_r + 9'd1;
        state_s      = HBP_ENTRY;
        strobe_cnt_s = 11'd0;
        pix_x_s      = 10'd0;
      end
    end else begin
      frame_done_s = 1'b0;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Sync history, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_d_r       <= 1'b0;
      vs_d_r       <= 1'b0;
      line_cnt_r   <= 10'd0;
      strobe_cnt_r <= 11'd0;
      pix_x_r      <= 10'd0;
      wr_en_r      <= 1'b0;
      wr_x_r       <= 10'd0;
      wr_y_r       <= 9'd0;
      wr_data_r    <= 4'd0;
      line_done_r  <= 1'b0;
      frame_done_r <= 1'b0;
      short_err_r  <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      hs_d_r       <= cap.hs;
      vs_d_r       <= cap.vs;
      line_cnt_r   <= line_cnt_s;
      strobe_cnt_r <= strobe_cnt_s;
      pix_x_r      <= pix_x_s;
      wr_en_r      <= wr_en_s;
      wr_x_r       <= wr_x_s;
      wr_y_r       <= wr_y_s;
      wr_data_r    <= wr_data_s;
      line_done_r  <= line_done_s;
      frame_done_r <= frame_done_s;
      short_err_r  <= short_err_s;
      frame_err_r  <= frame_err_s;
    end
  end

  assign cap.wr_en          = wr_en_r;
  assign cap.wr_x           = wr_x_r;
  assign cap.wr_y           = wr_y_r;
  assign cap.wr_data        = wr_data_r;
  assign cap.line_done      = line_done_r;
  assign cap.frame_done     = frame_done_r;
  assign cap.short_line_err = short_err_r;
  assign cap.frame_err      = frame_err_r;

`ifdef CAPTURE_HMEAS_EN
  logic [10:0] hcnt_r, hcnt_s;
  logic [10:0] meas_r, meas_s;

  // Count strobes between consecutive hsync falling edges regardless of state
  always_comb begin
    hcnt_s = hcnt_r;
    meas_s = meas_r;
    if (hs_fall_s) begin
      // a strobe landing on the edge itself belongs to the new line
      meas_s = hcnt_r;
      hcnt_s = cap.pix_valid ? 11'd1 : 11'd0;
    end else if (cap.pix_valid) begin
      hcnt_s = sat_inc11(hcnt_r);
    end else begin
      hcnt_s = hcnt_r;
    end
  end

  // Line-length measurement registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_r <= 11'd0;
      meas_r <= 11'd0;
    end else begin
      hcnt_r <= hcnt_s;
      meas_r <= meas_s;
    end
  end

  assign cap.meas_hcount = meas_r;
`else
  assign cap.meas_hcount = 11'd0;
`endif

  cga_line_capture_chk #(.H_ACTIVE(H_ACTIVE)) u_chk (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en_r),
    .wr_x           (wr_x_r),
    .line_done      (line_done_r),
    .frame_done     (frame_done_r),
    .short_line_err (short_err_r),
    .frame_err      (frame_err_r)
  );

endmodule

// File: tb/tb_cga_line_capture.sv
// tb_cga_line_capture: random and directed raster stimulus, an event-level
// reference model that queues expected writes/pulses, and a monitor that pops
// and compares whenever the DUT presents a write or pulse.
`timescale 1ns/1ps
module tb_cga_line_capture;
  localparam int HBP  = 4;
  localparam int HACT = 8;
  localparam int VBP  = 2;
  localparam int VACT = 3;

  logic clk = 1'b0;
  logic reset;
  always #4 clk = ~clk;

  cga_line_capture_if cap();

  cga_line_capture #(
    .H_BACKPORCH(HBP), .H_ACTIVE(HACT), .V_BACKPORCH(VBP), .V_ACTIVE(VACT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cap   (cap)
  );

  typedef struct { int cyc; int x; int y; int d; } wr_t;
  wr_t wr_q[$];
  int  ld_q[$];
  int  fd_q[$];

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int wr_seen = 0, ld_seen = 0, fd_seen = 0;
  bit mon_en = 1'b0;
  bit cur_hs = 1'b0, cur_vs = 1'b0;

  // reference model state: counts of edges and strobes, not a state machine
  bit m_prev_hs = 1'b0, m_prev_vs = 1'b0, m_armed = 1'b0;
  int m_nhs = 0, m_y = -1, m_k = 0;
  bit m_short = 1'b0, m_ferr = 1'b0;
  int m_hcnt = 0, m_meas = 0;

  // edge counter: value E at the negedge following edge E
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected DUT reaction to the inputs sampled at edge e.
  task automatic model(input int e, input bit rst, input bit pv, input logic [3:0] pd,
                       input bit hs, input bit vs);
    bit hf, vf, vr;
    wr_t t;
    hf = m_prev_hs & ~hs;
    vf = m_prev_vs & ~vs;
    vr = ~m_prev_vs & vs;
    m_prev_hs = rst ? 1'b0 : hs;
    m_prev_vs = rst ? 1'b0 : vs;
    if (rst) begin
      m_armed = 1'b0; m_y = -1; m_short = 1'b0; m_ferr = 1'b0; m_hcnt = 0; m_meas = 0;
      return;
    end
`ifdef CAPTURE_HMEAS_EN
    if (hf) begin
      m_meas = m_hcnt;
      m_hcnt = pv ? 1 : 0;
    end else if (pv) begin
      m_hcnt = (m_hcnt < 2047) ? m_hcnt + 1 : 2047;
    end
`endif
    if (m_armed && vr) begin
      m_ferr = 1'b1; m_armed = 1'b0; m_y = -1;
    end else if (!m_armed && vf) begin
      m_armed = 1'b1; m_nhs = 0; m_y = -1;
    end else if (m_armed && hf) begin
      if (m_y >= 0) begin
        if (m_k < HBP + HACT) begin
          m_short = 1'b1;
          ld_q.push_back(e);
        end
        if (m_y == VACT - 1) begin
          fd_q.push_back(e);
          m_armed = 1'b0;
        end
      end
      m_nhs++;
      m_y = (m_armed && m_nhs >= VBP) ? m_nhs - VBP : -1;
      m_k = 0;
    end else if (m_armed && pv && m_y >= 0) begin
      if (m_k >= HBP && m_k < HBP + HACT) begin
        t.cyc = e; t.x = m_k - HBP; t.y = m_y; t.d = int'(pd);
        wr_q.push_back(t);
        if (m_k - HBP == HACT - 1) ld_q.push_back(e);
      end
      m_k++;
    end
  endtask

  task automatic step(input bit rst, input bit pv, input logic [3:0] pd);
    reset         = rst;
    cap.pix_valid = pv;
    cap.pix_data  = pd;
    cap.hs        = cur_hs;
    cap.vs        = cur_vs;
    model(cyc + 1, rst, pv, pd, cur_hs, cur_vs);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0);
  endtask

  task automatic strobes(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      idle(rnd ? int'($urandom_range(6, 0)) : 8);
      step(1'b0, 1'b1, 4'($urandom_range(15, 0)));
    end
  endtask

  // hsync pulse; its falling edge is sampled by the step after this returns
  task automatic hpulse();
    cur_hs = 1'b1;
    idle(3);
    cur_hs = 1'b0;
  endtask

  task automatic line(input int n, input bit rnd);
    hpulse();
    idle(1);
    strobes(n, rnd);
  endtask

  task automatic vsfall();
    cur_vs = 1'b1;
    idle(4);
    cur_vs = 1'b0;
    idle(2);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, int'(cap.wr_en), 0);
    chk({tag, "_wr_x"}, int'(cap.wr_x), 0);
    chk({tag, "_wr_y"}, int'(cap.wr_y), 0);
    chk({tag, "_wr_data"}, int'(cap.wr_data), 0);
    chk({tag, "_line_done"}, int'(cap.line_done), 0);
    chk({tag, "_frame_done"}, int'(cap.frame_done), 0);
    chk({tag, "_short_err"}, int'(cap.short_line_err), 0);
    chk({tag, "_frame_err"}, int'(cap.frame_err), 0);
    chk({tag, "_meas"}, int'(cap.meas_hcount), 0);
  endtask

  task automatic clear_counts();
    wr_seen = 0; ld_seen = 0; fd_seen = 0;
  endtask

  task automatic reset_pulse(input string tag);
    step(1'b1, 1'b0, 4'h0);
    check_zero(tag);
    step(1'b1, 1'b0, 4'h0);
    clear_counts();
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_short_err"}, int'(cap.short_line_err), int'(m_short));
    chk({tag, "_frame_err"}, int'(cap.frame_err), int'(m_ferr));
    chk({tag, "_meas"}, int'(cap.meas_hcount), m_meas);
    chk({tag, "_wr_pending"}, wr_q.size(), 0);
    chk({tag, "_ld_pending"}, ld_q.size(), 0);
    chk({tag, "_fd_pending"}, fd_q.size(), 0);
  endtask

  wr_t mon_e;
  bit  mon_exp;

  // Monitor: pop expected entries and compare whenever a write or pulse is due or seen
  always @(negedge clk) begin
    if (mon_en) begin
      mon_exp = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
      if (cap.wr_en || mon_exp) begin
        chk("wr_en", int'(cap.wr_en), int'(mon_exp));
        if (mon_exp) begin
          mon_e = wr_q.pop_front();
          if (cap.wr_en) begin
            chk("wr_x", int'(cap.wr_x), mon_e.x);
            chk("wr_y", int'(cap.wr_y), mon_e.y);
            chk("wr_data", int'(cap.wr_data), mon_e.d);
          end
        end
        if (cap.wr_en) wr_seen++;
      end
      mon_exp = (ld_q.size() > 0) && (ld_q[0] == cyc);
      if (cap.line_done || mon_exp) begin
        chk("line_done", int'(cap.line_done), int'(mon_exp));
        if (mon_exp) void'(ld_q.pop_front());
        if (cap.line_done) ld_seen++;
      end
      mon_exp = (fd_q.size() > 0) && (fd_q[0] == cyc);
      if (cap.frame_done || mon_exp) begin
        chk("frame_done", int'(cap.frame_done), int'(mon_exp));
        if (mon_exp) void'(fd_q.pop_front());
        if (cap.frame_done) fd_seen++;
      end
    end
  end

  initial begin
    reset = 1'b1;
    cap.pix_valid = 1'b0; cap.pix_data = 4'h0; cap.hs = 1'b0; cap.vs = 1'b0;
    @(posedge clk);
    #1;
    reset_pulse("reset");
    mon_en = 1'b1;

    // strobes and hsync before any vsync falling edge must not be captured
    line(20, 1'b0);
    line(20, 1'b0);
    chk("pre_vsync_writes", wr_seen, 0);

    // nominal frame: 20 strobes per line, one every 9 clocks
    reset_pulse("nom_reset");
    vsfall();
    for (int j = 0; j < VBP + VACT; j++) line(20, 1'b0);
    idle(4);
    chk("nom_writes", wr_seen, HACT * VACT);
    chk("nom_line_done", ld_seen, VACT);
    chk("nom_frame_done", fd_seen, 1);
`ifdef CAPTURE_HMEAS_EN
    chk("nom_meas_const", int'(cap.meas_hcount), 20);
`else
    chk("nom_meas_const", int'(cap.meas_hcount), 0);
`endif
    checkpoint("nom");

    // short line: line 1 ends after five active pixels
    reset_pulse("short_reset");
    vsfall();
    line(20, 1'b0);
    line(20, 1'b0);
    line(HBP + 5, 1'b0);
    line(20, 1'b0);
    line(20, 1'b0);
    idle(4);
    chk("short_flag", int'(cap.short_line_err), 1);
    chk("short_writes", wr_seen, HACT + 5 + HACT);
    chk("short_line_done", ld_seen, VACT);
    checkpoint("short");

    // vsync rising during line 1 active region aborts the frame
    reset_pulse("abort_reset");
    vsfall();
    line(20, 1'b0);
    line(20, 1'b0);
    hpulse();
    idle(1);
    strobes(HBP + 3, 1'b0);
    cur_vs = 1'b1;
    idle(3);
    strobes(5, 1'b0);
    line(20, 1'b0);
    line(20, 1'b0);
    chk("abort_flag", int'(cap.frame_err), 1);
    chk("abort_writes", wr_seen, HACT + 3);
    vsfall();
    for (int j = 0; j < VBP + VACT; j++) line(20, 1'b0);
    idle(4);
    chk("abort_resume_writes", wr_seen, HACT + 3 + HACT * VACT);
    checkpoint("abort");

    // reset in the middle of the active region, with a strobe on the reset cycle
    reset_pulse("mid_pre");
    vsfall();
    line(20, 1'b0);
    hpulse();
    idle(1);
    strobes(HBP + 2, 1'b0);
    step(1'b1, 1'b1, 4'hA);
    check_zero("mid_reset");
    clear_counts();
    line(20, 1'b0);
    line(20, 1'b0);
    line(20, 1'b0);
    chk("mid_no_resume", wr_seen, 0);
    vsfall();
    for (int j = 0; j < VBP + VACT; j++) line(20, 1'b0);
    idle(4);
    chk("mid_resume_writes", wr_seen, HACT * VACT);
    checkpoint("mid");

    // randomized frames: varying line lengths, gaps, and one aborted frame
    reset_pulse("rand_reset");
    for (int f = 0; f < 4; f++) begin
      vsfall();
      for (int j = 0; j < VBP + VACT; j++) begin
        if (f == 1 && j == 3) begin
          hpulse();
          idle(1);
          strobes(int'($urandom_range(HBP + HACT - 1, 1)), 1'b1);
          cur_vs = 1'b1;
          idle(2);
        end else begin
          line(int'($urandom_range(HBP + HACT + 6, HBP + 2)), 1'b1);
        end
      end
      idle(3);
      checkpoint("rand");
    end

    idle(5);
    chk("end_wr_pending", wr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
